uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter for the Bluetooth note-player link, the sending counterpart of the UART receive path. It accepts 8-bit bytes over a valid/ready handshake into a one-byte holding register and shifts each out as a standard 8N1 frame. Bit timing comes from an internal baud counter derived from the system clock, so it needs no external tick. It sits between the status/echo logic and the Bluetooth module's RX pin.

## Interface

- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, serial bit rate in baud
- DIV (localparam) = CLK_FREQ / BAUD_RATE (integer division); clock cycles per bit; 10416 at defaults; legal range 2..65535
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to send, sampled on accept edge only
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  holding register empty; accept occurs on an edge where tx_valid && tx_ready
- tx  output  1  serial line, idle high, driven from a register
- busy  output  1  high while a frame is in flight or a byte is held

## Operation

- Frame format (8N1): start bit 0, then data bits 0..7 LSB first, then stop bit 1. Each bit is exactly DIV cycles. A full frame is 10*DIV cycles.
- Holding register: 8-bit data plus a hold_full flag. tx_ready = !hold_full.
  - An accept sets hold_full and captures tx_data.
  - tx_data is ignored on any edge where tx_ready is low.
- Shift path: 8-bit shifter, 3-bit bit index, 16-bit baud counter. The counter runs 0..DIV-1 and wraps to 0 at the end of each bit.
- FSM states:
  - IDLE: tx=1. If hold_full: load shifter from the holding register, clear hold_full, counter=0, go to START.
  - START: tx=0. At counter==DIV-1: go to DATA with bit index 0.
  - DATA: tx=shifter[0]. At counter==DIV-1: shift right. If index==7, go to STOP; else increment index.
  - STOP: tx=1. At counter==DIV-1:
    - If hold_full: load shifter, clear hold_full, go to START. This gives back-to-back frames with no idle gap.
    - Else go to IDLE.
- Clearing hold_full and accepting a new byte never happen on the same edge, because tx_ready is already low that cycle. After a transfer to the shifter, tx_ready rises on the next cycle.
- busy = (state != IDLE) || hold_full. It is registered or derived from registers only.
- No parity, no break generation, no flow control.

## Timing

- Reset values: tx=1, tx_ready=1, busy=0, state=IDLE, hold_full=0, counter=0, bit index=0, shifter=0.
- Reset is asynchronous, so tx returns to 1 immediately. A reset mid-frame aborts the frame and discards the held byte. Operation resumes normally on the first edge after rst deasserts.
- Latency when idle: accept at edge E. At edge E+1, tx falls (start bit) and tx_ready returns to 1.
  - Start bit occupies cycles E+1..E+DIV.
  - Data bit k begins at edge E+1+(k+1)*DIV.
  - Stop bit begins at edge E+1+9*DIV.
  - State returns to IDLE at edge E+1+10*DIV; busy falls there if nothing is held.
- Second byte accepted during a frame: tx_ready stays low from its accept edge until the edge where the current stop bit ends. On that edge, the next start bit begins (tx=0).
- tx_valid held high while tx_ready is low causes no state change. The byte is taken on the first edge where tx_ready is high.
- Counter never exceeds DIV-1; its wrap is the only bit-advance event.

## Test plan

- Reset: assert rst mid-run, then check tx=1, tx_ready=1, busy=0 before any clock edge; hold tx_valid=0 for 50 cycles and confirm tx stays 1.
- Single byte, CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10): accept 0xA5 at edge E, then check:
  - tx=0 for edges E+1..E+10.
  - Data bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - Stop bit 1 for 10 cycles.
  - busy falls at E+101.
- Back-to-back with DIV=10: accept 0x00, then accept 0xFF 5 cycles later. Check:
  - tx_ready is low from the second accept until the first stop bit ends.
  - The second start bit begins exactly at E+101.
  - Two contiguous frames totalling 200 cycles; busy falls at E+201.
- Back-pressure: with a frame active and the holding register full, drive tx_valid=1 while changing tx_data each cycle (0x11, 0x22, ...). Check that no extra byte is captured and the transmitted bytes match only the two accepted values.
- Reset mid-frame with DIV=10: pulse rst during data bit 3 of 0xC3. Check that tx goes to 1 immediately and tx_ready=1. Then send 0x3C and check the frame 0,0,0,1,1,1,1,0,0,1 at 10 cycles per bit.
- Defaults (DIV=10416): send 0x55 and measure 104160 cycles from start-bit falling edge to the end of the stop bit; each bit is 10416 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register and an internal baud counter.
// Bytes enter over a valid/ready handshake and leave LSB first on a registered serial line.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int          DIV      = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [7:0]  shifter;
    logic [2:0]  bit_idx;
    logic [15:0] cnt;

    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE) || hold_full;

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            shifter   <= 8'h00;
            bit_idx   <= 3'd0;
            cnt       <= 16'd0;
            tx        <= 1'b1;
        end else begin
            // An accept needs hold_full low, a transfer needs it high, so the
            // two writes to hold_full below can never collide.
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end

            case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= 16'd0;
                    if (hold_full) begin
                        shifter   <= hold_data;
                        hold_full <= 1'b0;
                        state     <= START;
                        tx        <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= shifter[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= 16'd0;
                        shifter <= shifter >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shifter[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= 16'd0;
                        // A held byte chains straight into the next start bit.
                        if (hold_full) begin
                            shifter   <= hold_data;
                            hold_full <= 1'b0;
                            state     <= START;
                            tx        <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at DIV=10: every cycle is compared with a frame-schedule
// model, plus directed checks on latency, back-to-back framing, back-pressure and reset.
module tb_uart_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = 10 * DIV;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference schedule: each accepted byte with its accept edge and start-bit edge.
    logic [7:0] byte_q[$];
    int         acc_q[$];
    int         st_q[$];
    int         last_end = 0;
    int         last_acc = 0;
    logic       accepted;

    logic tx_hist  [0:4095];
    logic rdy_hist [0:4095];
    logic busy_hist[0:4095];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic model_ready(input int t);
        foreach (acc_q[i])
            if (t >= acc_q[i] && t < st_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int t);
        foreach (acc_q[i])
            if (t >= acc_q[i] && t < st_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_tx(input int t);
        int k;
        foreach (st_q[i]) begin
            if (t >= st_q[i] && t < st_q[i] + FRAME) begin
                k = (t - st_q[i]) / DIV;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return byte_q[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic int hidx(input int t);
        return t & 4095;
    endfunction

    // Drive inputs for the coming edge, advance one edge, then compare all outputs.
    task automatic step(input logic v, input logic [7:0] d);
        int s;
        tx_valid = v;
        tx_data  = d;
        accepted = 1'b0;
        if (v && model_ready(cyc)) begin
            last_acc = cyc + 1;
            s = (last_end > last_acc + 1) ? last_end : last_acc + 1;
            byte_q.push_back(d);
            acc_q.push_back(last_acc);
            st_q.push_back(s);
            last_end = s + FRAME;
            accepted = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        tx_hist[hidx(cyc)]   = tx;
        rdy_hist[hidx(cyc)]  = tx_ready;
        busy_hist[hidx(cyc)] = busy;
        check("tx", 32'(tx), 32'(model_tx(cyc)));
        check("tx_ready", 32'(tx_ready), 32'(model_ready(cyc)));
        check("busy", 32'(busy), 32'(model_busy(cyc)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic check_frame(input string tag, input int e, input logic [7:0] b);
        logic [9:0] fv;
        fv = {1'b1, b, 1'b0};
        for (int j = 0; j < FRAME; j++)
            check(tag, 32'(tx_hist[hidx(e + 1 + j)]), 32'(fv[j / DIV]));
    endtask

    task automatic model_reset();
        byte_q.delete();
        acc_q.delete();
        st_q.delete();
        last_end = 0;
    endtask

    initial begin
        int         e;
        int         s;
        int         n;
        logic [7:0] b;
        logic [7:0] dec;

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset acts before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        idle(50);

        // Single byte 0xA5 from idle.
        step(1'b1, 8'hA5);
        e = last_acc;
        idle(110);
        check("a5_accept_ready", 32'(rdy_hist[hidx(e)]), 32'd0);
        check("a5_pre_start", 32'(tx_hist[hidx(e)]), 32'd1);
        check("a5_ready_back", 32'(rdy_hist[hidx(e + 1)]), 32'd1);
        check_frame("a5_frame", e, 8'hA5);
        check("a5_busy_last", 32'(busy_hist[hidx(e + 100)]), 32'd1);
        check("a5_busy_fall", 32'(busy_hist[hidx(e + 101)]), 32'd0);

        // Back-to-back 0x00 then 0xFF, with back-pressure on a full holding register.
        step(1'b1, 8'h00);
        e = last_acc;
        idle(4);
        step(1'b1, 8'hFF);
        check("b2b_second_accept", 32'(last_acc - e), 32'd5);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h11 * 8'(i + 1));
        idle(200);
        check("b2b_ready_low_first", 32'(rdy_hist[hidx(e + 5)]), 32'd0);
        check("b2b_ready_low_last", 32'(rdy_hist[hidx(e + 100)]), 32'd0);
        check("b2b_ready_high", 32'(rdy_hist[hidx(e + 101)]), 32'd1);
        check("b2b_stop_end", 32'(tx_hist[hidx(e + 100)]), 32'd1);
        check("b2b_start2", 32'(tx_hist[hidx(e + 101)]), 32'd0);
        check("b2b_busy_mid", 32'(busy_hist[hidx(e + 101)]), 32'd1);
        check("b2b_busy_last", 32'(busy_hist[hidx(e + 200)]), 32'd1);
        check("b2b_busy_fall", 32'(busy_hist[hidx(e + 201)]), 32'd0);
        // Independently decode the line mid-bit: exactly the two accepted bytes, then idle.
        for (int f = 0; f < 2; f++) begin
            s = e + 1 + f * FRAME;
            check("b2b_dec_start", 32'(tx_hist[hidx(s + DIV / 2)]), 32'd0);
            for (int k = 0; k < 8; k++) dec[k] = tx_hist[hidx(s + (k + 1) * DIV + DIV / 2)];
            check("b2b_dec_byte", 32'(dec), (f == 0) ? 32'h00 : 32'hFF);
            check("b2b_dec_stop", 32'(tx_hist[hidx(s + 9 * DIV + DIV / 2)]), 32'd1);
        end
        check("b2b_no_third", 32'(tx_hist[hidx(e + 1 + 2 * FRAME + DIV / 2)]), 32'd1);

        // Reset in the middle of data bit 3 of 0xC3, then a clean 0x3C frame.
        step(1'b1, 8'hC3);
        e = last_acc;
        idle(45);
        check("c3_bit3_low", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        idle(3);
        step(1'b1, 8'h3C);
        e = last_acc;
        idle(110);
        check_frame("3c_frame", e, 8'h3C);
        check("3c_busy_fall", 32'(busy_hist[hidx(e + 101)]), 32'd0);

        // Random bytes, random gaps, tx_data scrambled whenever the register is full.
        for (int r = 0; r < 8; r++) begin
            b = 8'($urandom);
            n = 0;
            do begin
                step(1'b1, model_ready(cyc) ? b : 8'($urandom));
                n++;
            end while (!accepted && n < 300);
            check("rand_accept", 32'(accepted), 32'd1);
            idle($urandom_range(0, 12));
        end
        idle(2 * FRAME + 10);
        check("rand_drain_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
